// File: rtl/alu_seq.sv
// Registered execute-stage ALU with a Start/Ready/Done handshake.
// Single-cycle ops finish at the Start edge; MUL/MULU/DIVU iterate one bit per cycle.
module alu_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [3:0]             Control,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] Shamt,
  output logic                   Ready,
  output logic                   Done,
  output logic [DATA_WIDTH-1:0]  Result,
  output logic [DATA_WIDTH-1:0]  ResultHi,
  output logic                   Zero,
  output logic                   Overflow
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_MULU = 4'b1110;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_opA;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic          r_neg;
  logic [W-1:0]  r_result;
  logic [W-1:0]  r_resultHi;
  logic          r_zero;
  logic          r_ovf;
  logic          r_done;

  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_diff;
  logic           w_shamtBig;
  logic [W-1:0]   w_sll;
  logic [W-1:0]   w_srl;
  logic [W-1:0]   w_sra;
  logic [W-1:0]   w_aluRes;
  logic           w_aluOvf;
  logic           w_isMul;
  logic           w_signedMul;
  logic [W-1:0]   w_magA;
  logic [W-1:0]   w_magB;
  logic           w_negate;
  logic [W:0]     w_mulSum;
  logic [2*W-1:0] w_mulProd;
  logic [2*W-1:0] w_mulFinal;
  logic [W:0]     w_divShift;
  logic [W:0]     w_divTrial;
  logic           w_divOk;
  logic [W-1:0]   w_divRem;
  logic [W-1:0]   w_divQuo;

  assign w_sum      = A + B;
  assign w_diff     = A - B;
  assign w_shamtBig = (32'(Shamt) >= 32'(W));
  assign w_sll      = w_shamtBig ? '0 : (B << Shamt);
  assign w_srl      = w_shamtBig ? '0 : (B >> Shamt);
  assign w_sra      = w_shamtBig ? {W{B[W-1]}} : $unsigned($signed(B) >>> Shamt);

  always_comb begin
    w_aluRes = '0;
    w_aluOvf = 1'b0;
    case (Control)
      OP_ADD: begin
        w_aluRes = w_sum;
        w_aluOvf = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        w_aluRes = w_diff;
        w_aluOvf = (A[W-1] != B[W-1]) && (w_diff[W-1] != A[W-1]);
      end
      OP_AND:  w_aluRes = A & B;
      OP_OR:   w_aluRes = A | B;
      OP_XOR:  w_aluRes = A ^ B;
      OP_LUI:  w_aluRes = B << (W / 2);
      OP_SLT:  w_aluRes = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR:  w_aluRes = ~(A | B);
      OP_SLL:  w_aluRes = w_sll;
      OP_SRL:  w_aluRes = w_srl;
      OP_SRA:  w_aluRes = w_sra;
      OP_SLTU: w_aluRes = {{(W-1){1'b0}}, (A < B)};
      default: w_aluRes = '0;
    endcase
  end

  // Signed MUL runs on magnitudes; the sign is reapplied to the full product at the end.
  assign w_isMul     = (Control == OP_MUL) || (Control == OP_MULU);
  assign w_signedMul = (Control == OP_MUL);
  assign w_magA      = (w_signedMul && A[W-1]) ? -A : A;
  assign w_magB      = (w_signedMul && B[W-1]) ? -B : B;
  assign w_negate    = w_signedMul && (A[W-1] ^ B[W-1]);

  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opA} : '0);
  assign w_mulProd  = {w_mulSum, r_lo[W-1:1]};
  assign w_mulFinal = r_neg ? -w_mulProd : w_mulProd;

  // Restoring divide: r_hi holds the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_divShift = {r_hi, r_lo[W-1]};
  assign w_divTrial = w_divShift - {1'b0, r_opA};
  assign w_divOk    = ~w_divTrial[W];
  assign w_divRem   = w_divOk ? w_divTrial[W-1:0] : w_divShift[W-1:0];
  assign w_divQuo   = {r_lo[W-2:0], w_divOk};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_opA      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg      <= 1'b0;
      r_result   <= '0;
      r_resultHi <= '0;
      r_zero     <= 1'b1;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_isMul) begin
              r_state <= S_MUL;
              r_count <= CNT_LOAD;
              r_opA   <= w_magA;
              r_hi    <= '0;
              r_lo    <= w_magB;
              r_neg   <= w_negate;
            end else if (Control == OP_DIVU) begin
              r_state <= S_DIV;
              r_count <= CNT_LOAD;
              r_opA   <= B;
              r_hi    <= '0;
              r_lo    <= A;
              r_neg   <= 1'b0;
            end else begin
              r_result   <= w_aluRes;
              r_resultHi <= '0;
              r_zero     <= (w_aluRes == '0);
              r_ovf      <= w_aluOvf;
              r_done     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_hi    <= w_mulSum[W:1];
          r_lo    <= {w_mulSum[0], r_lo[W-1:1]};
          r_count <= r_count - CW'(1);
          if (r_count == '0) begin
            r_state    <= S_IDLE;
            r_result   <= w_mulFinal[W-1:0];
            r_resultHi <= w_mulFinal[2*W-1:W];
            r_zero     <= (w_mulFinal[W-1:0] == '0);
            r_ovf      <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        S_DIV: begin
          r_hi    <= w_divRem;
          r_lo    <= w_divQuo;
          r_count <= r_count - CW'(1);
          if (r_count == '0) begin
            r_state    <= S_IDLE;
            r_result   <= w_divQuo;
            r_resultHi <= w_divRem;
            r_zero     <= (w_divQuo == '0);
            r_ovf      <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ready    = (r_state == S_IDLE);
  assign Done     = r_done;
  assign Result   = r_result;
  assign ResultHi = r_resultHi;
  assign Zero     = r_zero;
  assign Overflow = r_ovf;

endmodule
